// File: rtl/ext_domain_power_sequencer_pkg.sv
// Shared types and defaults for the external-domain power sequencer.
// No logic: state encoding, default timing constants, timer-width helper.
// Imported by the sequencer top and its bench.
package ext_pwr_seq_pkg;

  // Sequencer states; 3-bit encoding is fixed so it can be probed from the SoC.
  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_WAIT_ON  = 3'd1,
    ST_ISO_REL  = 3'd2,
    ST_RST_REL  = 3'd3,
    ST_ON       = 3'd4,
    ST_CLK_STOP = 3'd5,
    ST_ISO_SET  = 3'd6,
    ST_WAIT_OFF = 3'd7
  } pwr_state_e;

  localparam int unsigned TIMEOUT_DEF   = 64;
  localparam int unsigned ISO_DELAY_DEF = 2;
  localparam int unsigned RST_DELAY_DEF = 4;

  // Largest of the three delays; sizes the shared state timer.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ext_domain_power_sequencer_if.sv
// Control/status bundle between the power sequencer and the SoC/testharness.
// Pure wiring, no latency.
// No backpressure: level request in, level status out.
interface ext_domain_power_sequencer_if;

  logic power_on_i;
  logic err_clear_i;
  logic powergate_switch_ack_ni;
  logic powergate_switch_no;
  logic isolation_no;
  logic domain_rst_no;
  logic clk_en_o;
  logic powered_o;
  logic busy_o;
  logic err_o;

  // Sequencer side.
  modport slave (
    input  power_on_i, err_clear_i, powergate_switch_ack_ni,
    output powergate_switch_no, isolation_no, domain_rst_no, clk_en_o,
           powered_o, busy_o, err_o
  );

  // Requester / switch-cell side.
  modport master (
    output power_on_i, err_clear_i, powergate_switch_ack_ni,
    input  powergate_switch_no, isolation_no, domain_rst_no, clk_en_o,
           powered_o, busy_o, err_o
  );

endinterface

// File: rtl/ext_domain_power_sequencer_ack_sync.sv
// Optional 2-flop synchronizer for the active-low switch-cell ack (macro EXT_PWR_SEQ_ACK_SYNC_EN).
// Latency: 2 cycles when EXT_PWR_SEQ_ACK_SYNC_EN is defined, 0 (pass-through) otherwise.
// No backpressure; flops reset to 1 so a reset never looks like "powered".
module ext_pwr_seq_ack_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ack_ni,
  output logic ack_no
);

`ifdef EXT_PWR_SEQ_ACK_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  assign sync_d = {sync_q[0], ack_ni};

  // Two-stage shift toward the FSM; reset value reads as "switch off".
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign ack_no = sync_q[1];
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk_i ^ rst_i;
  assign ack_no         = ack_ni;
`endif

endmodule

// File: rtl/ext_domain_power_sequencer.sv
// Sequences switch, isolation, reset and clock-enable of one power-gated domain (optional ack sync: EXT_PWR_SEQ_ACK_SYNC_EN).
// Latency: outputs follow the deciding edge by 1 cycle; up-sequence = ack wait + ISO_DELAY + RST_DELAY.
// No backpressure: power_on_i is a level, only looked at in OFF and ON; ack waits are bounded by TIMEOUT.
module ext_domain_power_sequencer
  import ext_pwr_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
  parameter int unsigned ISO_DELAY = ISO_DELAY_DEF,
  parameter int unsigned RST_DELAY = RST_DELAY_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  ext_domain_power_sequencer_if.slave   pwr_if
);

  localparam int CNT_W = $clog2(max3(TIMEOUT, ISO_DELAY, RST_DELAY) + 1);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_DELAY - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  pwr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             err_set;
  logic             ack_n;

  logic sw_n, iso_n, rst_n, clk_en, powered, busy;

  ext_pwr_seq_ack_sync u_ack_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .ack_ni (pwr_if.powergate_switch_ack_ni),
    .ack_no (ack_n)
  );

  // Next state; a timeout in either ack wait raises the sticky error.
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (pwr_if.power_on_i && !err_q) state_d = ST_WAIT_ON;
      end
      ST_WAIT_ON: begin
        if (!ack_n) begin
          state_d = ST_ISO_REL;
        end else if (cnt_q == TO_LAST) begin
          err_set = 1'b1;
          state_d = ST_WAIT_OFF;
        end
      end
      ST_ISO_REL: begin
        if (cnt_q == ISO_LAST) state_d = ST_RST_REL;
      end
      ST_RST_REL: begin
        if (cnt_q == RST_LAST) state_d = ST_ON;
      end
      ST_ON: begin
        if (!pwr_if.power_on_i) state_d = ST_CLK_STOP;
      end
      ST_CLK_STOP: begin
        state_d = ST_ISO_SET;
      end
      ST_ISO_SET: begin
        if (cnt_q == ISO_LAST) state_d = ST_WAIT_OFF;
      end
      ST_WAIT_OFF: begin
        if (ack_n) begin
          state_d = ST_OFF;
        end else if (cnt_q == TO_LAST) begin
          err_set = 1'b1;
          state_d = ST_OFF;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Timer restarts at 0 on every state change and saturates otherwise; error set beats clear.
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
    err_d = err_set ? 1'b1 : (pwr_if.err_clear_i ? 1'b0 : err_q);
  end

  // State, timer and error registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Output decode from state only; defaults are the fully-off values.
  always_comb begin
    sw_n    = 1'b1;
    iso_n   = 1'b0;
    rst_n   = 1'b0;
    clk_en  = 1'b0;
    powered = 1'b0;
    busy    = 1'b1;
    case (state_q)
      ST_OFF: begin
        busy = 1'b0;
      end
      ST_WAIT_ON: begin
        sw_n = 1'b0;
      end
      ST_ISO_REL: begin
        sw_n  = 1'b0;
        iso_n = 1'b1;
      end
      ST_RST_REL: begin
        sw_n   = 1'b0;
        iso_n  = 1'b1;
        clk_en = 1'b1;
      end
      ST_ON: begin
        sw_n    = 1'b0;
        iso_n   = 1'b1;
        clk_en  = 1'b1;
        rst_n   = 1'b1;
        powered = 1'b1;
        busy    = 1'b0;
      end
      ST_CLK_STOP: begin
        sw_n  = 1'b0;
        iso_n = 1'b1;
      end
      ST_ISO_SET: begin
        sw_n = 1'b0;
      end
      ST_WAIT_OFF: begin
        sw_n = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign pwr_if.powergate_switch_no = sw_n;
  assign pwr_if.isolation_no        = iso_n;
  assign pwr_if.domain_rst_no       = rst_n;
  assign pwr_if.clk_en_o            = clk_en;
  assign pwr_if.powered_o           = powered;
  assign pwr_if.busy_o              = busy;
  assign pwr_if.err_o               = err_q;

endmodule

// File: tb/tb_ext_domain_power_sequencer.sv
// Bench for ext_domain_power_sequencer: vector tables, ordering monitor, randomized run vs. reference model.
// Ack model: switch enable seen back on the ack 15 cycles later (or stuck high/low).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ext_domain_power_sequencer;

`ifdef EXT_PWR_SEQ_ACK_SYNC_EN
  localparam int AL = 2;
`else
  localparam int AL = 0;
`endif

  // Expected output words {switch_no, iso_no, rst_no, clk_en, powered, busy, err}.
  localparam logic [6:0] E_OFF  = 7'b1000000;
  localparam logic [6:0] E_WON  = 7'b0000010;
  localparam logic [6:0] E_ISO  = 7'b0100010;
  localparam logic [6:0] E_RST  = 7'b0101010;
  localparam logic [6:0] E_ON   = 7'b0111100;
  localparam logic [6:0] E_CS   = 7'b0100010;
  localparam logic [6:0] E_ISET = 7'b0000010;
  localparam logic [6:0] E_WOFF = 7'b1000010;
  localparam logic [6:0] ERR    = 7'b0000001;

  // Reference model phases.
  localparam int P_OFF = 0, P_WON = 1, P_ISO = 2, P_RST = 3, P_ON = 4, P_CS = 5, P_ISET = 6, P_WOFF = 7;

  typedef struct {
    int         cyc;
    bit         pon;
    bit         clr;
    bit         rst;
    logic [6:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_s = 1'b1;
  logic rst_edge = 1'b1;
  always #5 clk = ~clk;

  ext_domain_power_sequencer_if bus();

  ext_domain_power_sequencer #(
    .TIMEOUT   (64),
    .ISO_DELAY (2),
    .RST_DELAY (4)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_s),
    .pwr_if (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit pon = 1'b0, clr = 1'b0, rst = 1'b1;
  int ack_mode = 0;               // 0: delayed switch, 1: stuck high, 2: stuck low
  logic [15:0] sw_hist = '1;
  vec_t vec[$];

  // Reference model state.
  int m_ph = P_OFF;
  int m_ent = 0;
  bit m_err = 1'b0;
  bit m_s1 = 1'b1, m_s2 = 1'b1;

  function automatic logic [6:0] outs();
    return {bus.powergate_switch_no, bus.isolation_no, bus.domain_rst_no, bus.clk_en_o,
            bus.powered_o, bus.busy_o, bus.err_o};
  endfunction

  function automatic logic [6:0] model_out();
    logic [6:0] e;
    case (m_ph)
      P_OFF:   e = E_OFF;
      P_WON:   e = E_WON;
      P_ISO:   e = E_ISO;
      P_RST:   e = E_RST;
      P_ON:    e = E_ON;
      P_CS:    e = E_CS;
      P_ISET:  e = E_ISET;
      default: e = E_WOFF;
    endcase
    return m_err ? (e | ERR) : e;
  endfunction

  // Advance the model over the edge that ends cycle `cyc`; phase age is measured in absolute cycles.
  function automatic void model_step(bit p, bit c, bit r, bit a);
    bit obs;
    int age;
    int nx;
    bit set;
    if (r) begin
      m_ph  = P_OFF;
      m_err = 1'b0;
      m_ent = cyc + 1;
      m_s1  = 1'b1;
      m_s2  = 1'b1;
      return;
    end
    obs  = (AL != 0) ? m_s2 : a;
    m_s2 = m_s1;
    m_s1 = a;
    age  = cyc - m_ent;
    nx   = m_ph;
    set  = 1'b0;
    case (m_ph)
      P_OFF:  if (p && !m_err) nx = P_WON;
      P_WON:  if (!obs) nx = P_ISO; else if (age == 63) begin nx = P_WOFF; set = 1'b1; end
      P_ISO:  if (age == 1) nx = P_RST;
      P_RST:  if (age == 3) nx = P_ON;
      P_ON:   if (!p) nx = P_CS;
      P_CS:   nx = P_ISET;
      P_ISET: if (age == 1) nx = P_WOFF;
      default: if (obs) nx = P_OFF; else if (age == 63) begin nx = P_OFF; set = 1'b1; end
    endcase
    m_err = set ? 1'b1 : (c ? 1'b0 : m_err);
    if (nx != m_ph) begin
      m_ph  = nx;
      m_ent = cyc + 1;
    end
  endfunction

  task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b (sw,iso,rst,clk,pwr,busy,err)", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs (plus the modelled ack), step the model, advance one clock.
  task automatic tick();
    logic ack;
    sw_hist = {sw_hist[14:0], bus.powergate_switch_no};
    case (ack_mode)
      0:       ack = sw_hist[15];
      1:       ack = 1'b1;
      default: ack = 1'b0;
    endcase
    bus.powergate_switch_ack_ni = ack;
    bus.power_on_i  = pon;
    bus.err_clear_i = clr;
    rst_s = rst;
    model_step(pon, clr, rst, ack);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input string nm);
    pon = 1'b0;
    clr = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sw_hist = '1;
    check(nm, outs(), E_OFF);
  endtask

  task automatic add(input int c, input bit p, input bit cl, input bit r, input logic [6:0] e);
    vec_t v;
    v.cyc = c; v.pon = p; v.clr = cl; v.rst = r; v.exp = e;
    vec.push_back(v);
  endtask

  // Row k: check outputs at cycle k, then apply its inputs; pon held, clr/rst are one-cycle pulses.
  task automatic run_vec(input string nm);
    int idx;
    int last;
    idx  = 0;
    last = vec[vec.size() - 1].cyc;
    for (int k = 0; k <= last; k++) begin
      clr = 1'b0;
      rst = 1'b0;
      if (idx < vec.size() && vec[idx].cyc == k) begin
        check($sformatf("%s cyc=%0d", nm, k), outs(), vec[idx].exp);
        pon = vec[idx].pon;
        clr = vec[idx].clr;
        rst = vec[idx].rst;
        idx++;
      end
      tick();
    end
    clr = 1'b0;
    rst = 1'b0;
    vec.delete();
  endtask

  // Remember whether the last edge was a reset edge.
  always @(posedge clk) rst_edge <= rst_s;

  // Ordering monitor: clock/reset before isolation, isolation before switch-off, clock before reset release.
  logic p_sw = 1'bx, p_iso = 1'bx, p_rstn = 1'bx, p_clk = 1'bx;
  always @(negedge clk) begin
    if (rst_edge === 1'b0) begin
      if (p_iso === 1'b1 && bus.isolation_no === 1'b0) begin
        n_cmp++;
        if (!(p_clk === 1'b0 && p_rstn === 1'b0)) begin
          n_err++;
          $display("FAIL order_iso: clk_en=%b rst_no=%b before isolation, want 0 0", p_clk, p_rstn);
        end
      end
      if (p_sw === 1'b0 && bus.powergate_switch_no === 1'b1) begin
        n_cmp++;
        if (p_iso !== 1'b0) begin
          n_err++;
          $display("FAIL order_sw: iso_no=%b before switch-off, want 0", p_iso);
        end
      end
      if (p_rstn === 1'b0 && bus.domain_rst_no === 1'b1) begin
        n_cmp++;
        if (p_clk !== 1'b1) begin
          n_err++;
          $display("FAIL order_rst: clk_en=%b before reset release, want 1", p_clk);
        end
      end
    end
    p_sw   = bus.powergate_switch_no;
    p_iso  = bus.isolation_no;
    p_rstn = bus.domain_rst_no;
    p_clk  = bus.clk_en_o;
  end

  initial begin
    bus.power_on_i = 1'b0;
    bus.err_clear_i = 1'b0;
    bus.powergate_switch_ack_ni = 1'b1;
    @(negedge clk);

    // Power-up then power-down with the 15-cycle ack model.
    ack_mode = 0;
    do_reset("reset_s1");
    add(0, 1, 0, 0, E_OFF);
    add(1, 1, 0, 0, E_WON);
    add(16 + AL, 1, 0, 0, E_WON);
    add(17 + AL, 1, 0, 0, E_ISO);
    add(18 + AL, 1, 0, 0, E_ISO);
    add(19 + AL, 1, 0, 0, E_RST);
    add(22 + AL, 1, 0, 0, E_RST);
    add(23 + AL, 1, 0, 0, E_ON);
    add(30 + AL, 0, 0, 0, E_ON);
    add(31 + AL, 0, 0, 0, E_CS);
    add(32 + AL, 0, 0, 0, E_ISET);
    add(33 + AL, 0, 0, 0, E_ISET);
    add(34 + AL, 0, 0, 0, E_WOFF);
    add(49 + 2 * AL, 0, 0, 0, E_WOFF);
    add(50 + 2 * AL, 0, 0, 0, E_OFF);
    run_vec("updown");

    // Ack stuck high: timeout (clear coinciding with it loses), sticky error, clear, retry, reset clears error.
    ack_mode = 1;
    do_reset("reset_s3");
    add(0, 1, 0, 0, E_OFF);
    add(64, 1, 1, 0, E_WON);
    add(65, 1, 0, 0, E_WOFF | ERR);
    add(66, 1, 0, 0, E_OFF | ERR);
    add(76, 1, 1, 0, E_OFF | ERR);
    add(77, 1, 0, 0, E_OFF);
    add(78, 1, 0, 0, E_WON);
    add(142, 1, 0, 0, E_WOFF | ERR);
    add(143, 1, 0, 0, E_OFF | ERR);
    add(145, 0, 0, 1, E_OFF | ERR);
    add(146, 0, 0, 0, E_OFF);
    run_vec("timeout");

    // One-cycle request pulse: full up-sequence, then immediate power-down.
    ack_mode = 0;
    do_reset("reset_s4");
    add(0, 1, 0, 0, E_OFF);
    add(1, 0, 0, 0, E_WON);
    add(23 + AL, 0, 0, 0, E_ON);
    add(24 + AL, 0, 0, 0, E_CS);
    add(25 + AL, 0, 0, 0, E_ISET);
    add(42 + 2 * AL, 0, 0, 0, E_WOFF);
    add(43 + 2 * AL, 0, 0, 0, E_OFF);
    run_vec("pulse");

    // Reset in the middle of reset-release.
    do_reset("reset_s5");
    add(0, 1, 0, 0, E_OFF);
    add(20 + AL, 1, 0, 1, E_RST);
    add(21 + AL, 0, 0, 0, E_OFF);
    add(22 + AL, 0, 0, 0, E_OFF);
    run_vec("rst_mid");

    // Ack already low on entry to WAIT_ON: leaves on the next cycle the ack is seen.
    ack_mode = 2;
    do_reset("reset_s6");
    add(0, 1, 0, 0, E_OFF);
    add(1, 1, 0, 0, E_WON);
    add(2 + AL, 1, 0, 0, E_ISO);
    run_vec("ack_early");

    // Randomized run against the reference model.
    ack_mode = 0;
    do_reset("reset_rand");
    for (int i = 0; i < 6000; i++) begin
      check($sformatf("rand cyc=%0d", i), outs(), model_out());
      if (i % 300 == 0) ack_mode = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 2));
      if ($urandom_range(0, 24) == 0) pon = ~pon;
      clr = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 799) == 0);
      tick();
    end
    check("rand_final", outs(), model_out());

    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
